// File: rtl/t05_huff_decoder_pkg.sv
// Shared definitions for the Huffman codebook/decoder slice.
// Contents:
//   dec_state_t                decoder FSM states
//   child_kind_t               classification of a 9-bit child field
//   NULL_ELEM                  encoding of an absent child
//   LSE_HI/LO, RSE_HI/LO       left/right child field positions in an htree element
//   select_child/classify_child helpers for the decode walk
package t05_pkg;

  localparam int unsigned ELEM_W = 71;

  // Child field positions inside an htree element.
  localparam int unsigned LSE_HI = 63;
  localparam int unsigned LSE_LO = 55;
  localparam int unsigned RSE_HI = 54;
  localparam int unsigned RSE_LO = 46;

  localparam logic [8:0] NULL_ELEM = 9'b110000000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BIT,
    EMIT,
    DONE,
    ERR
  } dec_state_t;

  typedef enum logic [1:0] {
    CHILD_LEAF,
    CHILD_NODE,
    CHILD_NULL
  } child_kind_t;

  // Bit 0 walks left, bit 1 walks right.
  function automatic logic [8:0] select_child(input logic [8:0] left,
                                              input logic [8:0] right,
                                              input logic       dir);
    return dir ? right : left;
  endfunction

  // NULL_ELEM has bit8 set, so it must be recognised before the node test.
  function automatic child_kind_t classify_child(input logic [8:0] c);
    if (c == NULL_ELEM) return CHILD_NULL;
    if (!c[8]) return CHILD_LEAF;
    return CHILD_NODE;
  endfunction

endpackage

// File: rtl/t05_huff_decoder_if.sv
// Bus bundle for the Huffman decoder.
// Groups the control (start/max_index/total_chars), htree memory read port
// (h_addr/h_element), bit input handshake (bit_in/bit_valid/bit_ready),
// character output handshake (char_out/char_valid/char_ready) and status
// (done/error/busy).
// Modports: slave = decoder side, master = environment side.
interface t05_huff_decoder_if #(
  parameter int unsigned IDX_W = 7
);
  import t05_pkg::*;

  logic              start;
  logic [IDX_W-1:0]  max_index;
  logic [7:0]        total_chars;
  logic [IDX_W-1:0]  h_addr;
  logic [ELEM_W-1:0] h_element;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic [7:0]        char_out;
  logic              char_valid;
  logic              char_ready;
  logic              done;
  logic              error;
  logic              busy;

  modport slave (
    input  start, max_index, total_chars, h_element, bit_in, bit_valid, char_ready,
    output h_addr, bit_ready, char_out, char_valid, done, error, busy
  );

  modport master (
    output start, max_index, total_chars, h_element, bit_in, bit_valid, char_ready,
    input  h_addr, bit_ready, char_out, char_valid, done, error, busy
  );

endinterface

// File: rtl/t05_huff_decoder.sv
// Huffman bitstream decoder.
// Walks the htree from the root one encoded bit at a time and emits one
// 8-bit character per leaf reached, refetching the root after each leaf.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  t05_huff_decoder_if.slave: start/max_index/total_chars control,
//        h_addr/h_element htree read port (element valid one cycle after
//        h_addr changes), bit_in/bit_valid/bit_ready bit handshake,
//        char_out/char_valid/char_ready character handshake,
//        done/error/busy status.
module t05_huff_decoder
  import t05_pkg::*;
#(
  parameter int unsigned IDX_W     = 7,
  parameter int unsigned MAX_DEPTH = 127
) (
  input  logic                     clk,
  input  logic                     rst,
  t05_huff_decoder_if.slave        bus
);

  dec_state_t       state_q, state_d;
  logic [IDX_W-1:0] curr_index_q, curr_index_d;
  logic [IDX_W-1:0] root_q, root_d;
  logic [6:0]       depth_q, depth_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       target_q, target_d;
  logic [7:0]       char_out_q, char_out_d;

  logic [8:0]       left_child;
  logic [8:0]       right_child;
  logic [8:0]       child;
  child_kind_t      child_kind;

  // Element fields outside the child pointers are not needed here.
  logic unused_elem_bits;
  assign unused_elem_bits = ^{bus.h_element[ELEM_W-1:LSE_HI+1],
                              bus.h_element[RSE_LO-1:0]};

  assign left_child  = bus.h_element[LSE_HI:LSE_LO];
  assign right_child = bus.h_element[RSE_HI:RSE_LO];
  assign child       = select_child(left_child, right_child, bus.bit_in);
  assign child_kind  = classify_child(child);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      curr_index_q <= '0;
      root_q       <= '0;
      depth_q      <= '0;
      count_q      <= '0;
      target_q     <= '0;
      char_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      curr_index_q <= curr_index_d;
      root_q       <= root_d;
      depth_q      <= depth_d;
      count_q      <= count_d;
      target_q     <= target_d;
      char_out_q   <= char_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    curr_index_d = curr_index_q;
    root_d       = root_q;
    depth_d      = depth_q;
    count_d      = count_q;
    target_d     = target_q;
    char_out_d   = char_out_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          root_d       = bus.max_index;
          curr_index_d = bus.max_index;
          target_d     = bus.total_chars;
          depth_d      = '0;
          count_d      = '0;
          state_d      = (bus.total_chars == 8'd0) ? DONE : FETCH;
        end
      end

      FETCH: state_d = BIT;

      BIT: begin
        if (bus.bit_valid) begin
          unique case (child_kind)
            CHILD_NULL: state_d = ERR;
            CHILD_LEAF: begin
              char_out_d   = child[7:0];
              curr_index_d = root_q;
              depth_d      = '0;
              state_d      = EMIT;
            end
            default: begin
              if (depth_q == 7'(MAX_DEPTH - 1)) begin
                state_d = ERR;
              end else begin
                curr_index_d = child[IDX_W-1:0];
                depth_d      = depth_q + 7'd1;
                state_d      = FETCH;
              end
            end
          endcase
        end
      end

      EMIT: begin
        if (bus.char_ready) begin
          count_d = count_q + 8'd1;
          state_d = (count_q + 8'd1 == target_q) ? DONE : FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.h_addr     = curr_index_q;
  assign bus.char_out   = char_out_q;
  assign bus.bit_ready  = (state_q == BIT);
  assign bus.char_valid = (state_q == EMIT);
  assign bus.done       = (state_q == DONE);
  assign bus.error      = (state_q == ERR);
  assign bus.busy       = (state_q == FETCH) || (state_q == BIT) || (state_q == EMIT);

endmodule
